// File: rtl/sprite_table_writer.sv
// Producer side of the sprite-position table: serialises sprite updates and count writes into BRAM port A.
// Build option: define SPRITE_CLAMP_EN to clamp written X/Y to X_MAX/Y_MAX.
module sprite_table_writer #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 16,
   parameter int COORD_W     = 10,
   parameter int MAX_SPRITES = 16,
   parameter int X_MAX       = 639,
   parameter int Y_MAX       = 479
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               upd_valid,
   output logic               upd_ready,
   input  logic [4:0]         upd_index,
   input  logic [COORD_W-1:0] upd_x,
   input  logic [COORD_W-1:0] upd_y,
   input  logic               cnt_valid,
   input  logic [4:0]         cnt_value,
   input  logic               hold,
   output logic [ADDR_W-1:0]  addr_a,
   output logic [DATA_W-1:0]  data_a,
   output logic               we_a,
   output logic               busy,
   output logic               err_index
);

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_WX   = 3'd2;
   localparam logic [2:0] S_WY   = 3'd3;
   localparam logic [2:0] S_WCNT = 3'd4;

   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(2 * MAX_SPRITES);
   localparam logic [5:0]         IDX_LIMIT = 6'(MAX_SPRITES);
   localparam logic [COORD_W-1:0] X_CEIL    = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] Y_CEIL    = COORD_W'(Y_MAX);

`ifdef SPRITE_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   logic [2:0]         state;
   logic [4:0]         cnt_reg;
   logic [4:0]         idx_reg;
   logic [COORD_W-1:0] y_reg;
   logic [COORD_W-1:0] x_in;
   logic [COORD_W-1:0] y_in;
   logic               idx_ok;

   assign x_in   = (CLAMP_EN && (upd_x > X_CEIL)) ? X_CEIL : upd_x;
   assign y_in   = (CLAMP_EN && (upd_y > Y_CEIL)) ? Y_CEIL : upd_y;
   assign idx_ok = {1'b0, upd_index} < IDX_LIMIT;

   // NOTE: upd_ready must react to hold/cnt_valid in the same cycle, so it is decoded from the state register rather than registered itself.
   assign upd_ready = (state == S_IDLE) && !hold && !cnt_valid;
   assign busy      = (state != S_IDLE);

   function automatic logic [ADDR_W-1:0] slot_addr(input logic [4:0] idx, input logic [1:0] offset);
      return ADDR_W'({idx, 1'b0}) + ADDR_W'(offset);
   endfunction

   // NOTE: the BRAM contents are not reset here; INIT re-zeroes the table by writing it after every reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_INIT;
         addr_a    <= '0;
         data_a    <= '0;
         we_a      <= 1'b0;
         err_index <= 1'b0;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         y_reg     <= '0;
      end else begin
         // Write strobe and error are single-cycle; states below raise them when needed.
         we_a      <= 1'b0;
         err_index <= 1'b0;
         case (state)
            S_INIT: begin
               if (we_a && (addr_a == LAST_ADDR)) begin
                  state <= S_IDLE;
               end else begin
                  we_a   <= 1'b1;
                  addr_a <= we_a ? addr_a + 1'b1 : '0;
                  data_a <= '0;
               end
            end
            S_IDLE: begin
               if (cnt_valid && !hold) begin
                  we_a    <= 1'b1;
                  addr_a  <= '0;
                  data_a  <= DATA_W'(cnt_value);
                  cnt_reg <= cnt_value;
                  state   <= S_WCNT;
               end else if (upd_valid && upd_ready) begin
                  if (idx_ok) begin
                     we_a    <= 1'b1;
                     addr_a  <= slot_addr(upd_index, 2'd1);
                     data_a  <= DATA_W'(x_in);
                     idx_reg <= upd_index;
                     y_reg   <= y_in;
                     state   <= S_WX;
                  end else begin
                     err_index <= 1'b1;
                  end
               end
            end
            S_WX: begin
               we_a   <= 1'b1;
               addr_a <= slot_addr(idx_reg, 2'd2);
               data_a <= DATA_W'(y_reg);
               state  <= S_WY;
            end
            S_WY: begin
               // Growing past the current count extends the table the reader walks.
               if (idx_reg >= cnt_reg) begin
                  we_a    <= 1'b1;
                  addr_a  <= '0;
                  data_a  <= DATA_W'(idx_reg) + 1'b1;
                  cnt_reg <= idx_reg + 5'd1;
                  state   <= S_WCNT;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WCNT:  state <= S_IDLE;
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_table_writer.sv
// Self-checking bench for sprite_table_writer: directed cases plus random updates against a table-level model.
module tb_sprite_table_writer;

   localparam int ADDR_W      = 10;
   localparam int DATA_W      = 16;
   localparam int COORD_W     = 10;
   localparam int MAX_SPRITES = 16;
   localparam int TBL_LAST    = 2 * MAX_SPRITES;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               upd_valid;
   logic               upd_ready;
   logic [4:0]         upd_index;
   logic [COORD_W-1:0] upd_x;
   logic [COORD_W-1:0] upd_y;
   logic               cnt_valid;
   logic [4:0]         cnt_value;
   logic               hold;
   logic [ADDR_W-1:0]  addr_a;
   logic [DATA_W-1:0]  data_a;
   logic               we_a;
   logic               busy;
   logic               err_index;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   int  count = 0;
   wr_t got_q[$];
   wr_t exp_q[$];
   int  shadow[0:1023];
   int  model_tbl[0:TBL_LAST];

   sprite_table_writer dut (
      .clk       (clk),
      .reset     (reset),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_index (upd_index),
      .upd_x     (upd_x),
      .upd_y     (upd_y),
      .cnt_valid (cnt_valid),
      .cnt_value (cnt_value),
      .hold      (hold),
      .addr_a    (addr_a),
      .data_a    (data_a),
      .we_a      (we_a),
      .busy      (busy),
      .err_index (err_index)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every BRAM write with the edge number that produced it.
   always @(negedge clk) begin
      if (reset === 1'b1 && we_a === 1'b1) begin
         got_q.push_back('{cyc, int'(addr_a), int'(data_a)});
         shadow[addr_a] = int'(data_a);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int c, input int a, input int d);
      exp_q.push_back('{c, a, d});
      model_tbl[a] = d;
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_nwr"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_cyc%0d", tag, i), got_q[i].cyc, exp_q[i].cyc);
         check($sformatf("%s_addr%0d", tag, i), got_q[i].addr, exp_q[i].addr);
         check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle", busy, 1'b0);
   endtask

   task automatic release_reset();
      int e0;
      @(posedge clk); #1;
      reset = 1'b1;
      e0 = cyc + 1;
      count = 0;
      for (int k = 0; k <= TBL_LAST; k++) push_exp(e0 + k, k, 0);
      wait_idle();
      check("ready_after_init", upd_ready, 1'b1);
      compare_writes("init");
   endtask

   task automatic do_count(input int v, input bit settle);
      int e;
      cnt_valid = 1'b1;
      cnt_value = v[4:0];
      #1;
      if (upd_valid) check("cnt_prio_ready", upd_ready, 1'b0);
      @(posedge clk); #1;
      e = cyc;
      cnt_valid = 1'b0;
      push_exp(e, 0, v);
      count = v;
      if (settle) begin
         wait_idle();
         compare_writes("cnt");
      end
   endtask

   task automatic do_update(input int idx, input int x, input int y, input bit hold_mid, input bit rst_wy);
      int e;
      int n;
      int xe;
      int ye;
      upd_index = idx[4:0];
      upd_x     = x[COORD_W-1:0];
      upd_y     = y[COORD_W-1:0];
      upd_valid = 1'b1;
      n = 0;
      #1;
      while (!upd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("accept", upd_ready, 1'b1);
      @(posedge clk); #1;
      e = cyc;
      upd_valid = 1'b0;
`ifdef SPRITE_CLAMP_EN
      xe = (x > 639) ? 639 : x;
      ye = (y > 479) ? 479 : y;
`else
      xe = x;
      ye = y;
`endif
      if (idx >= MAX_SPRITES) begin
         check("err_pulse", err_index, 1'b1);
         check("err_no_we", we_a, 1'b0);
         @(posedge clk); #1;
         check("err_clear", err_index, 1'b0);
      end else begin
         push_exp(e, 2 * idx + 1, xe);
         if (hold_mid) hold = 1'b1;
         if (rst_wy) begin
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            check("rst_we", we_a, 1'b0);
            check("rst_addr", addr_a, '0);
            check("rst_busy", busy, 1'b1);
            check("rst_ready", upd_ready, 1'b0);
            compare_writes("rst_mid");
            return;
         end
         push_exp(e + 1, 2 * idx + 2, ye);
         if (idx >= count) begin
            push_exp(e + 2, 0, idx + 1);
            count = idx + 1;
         end
      end
      wait_idle();
      hold = 1'b0;
      compare_writes($sformatf("upd%0d", idx));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      upd_valid = 1'b0; upd_index = '0; upd_x = '0; upd_y = '0;
      cnt_valid = 1'b0; cnt_value = '0; hold = 1'b0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr_a", addr_a, '0);
      check("rst_data_a", data_a, '0);
      check("rst_we_a", we_a, 1'b0);
      check("rst_upd_ready", upd_ready, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_err", err_index, 1'b0);
      release_reset();

      do_update(0, 100, 200, 1'b0, 1'b0);
      do_update(3, 5, 7, 1'b0, 1'b0);
      do_update(1, 9, 11, 1'b0, 1'b0);

      // Count write wins over a simultaneous update, which then follows.
      upd_index = 5'd4; upd_x = 10'd40; upd_y = 10'd41; upd_valid = 1'b1;
      do_count(2, 1'b0);
      do_update(4, 40, 41, 1'b0, 1'b0);

      hold = 1'b1;
      upd_index = 5'd5; upd_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold_ready", upd_ready, 1'b0);
         check("hold_we", we_a, 1'b0);
         @(posedge clk); #1;
      end
      hold = 1'b0;
      do_update(5, 50, 51, 1'b0, 1'b0);

      do_update(6, 60, 61, 1'b1, 1'b0);
      do_update(20, 1, 1, 1'b0, 1'b0);
      do_update(2, 700, 600, 1'b0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            do_count(int'($urandom_range(0, 20)), 1'b1);
         end else begin
            do_update(int'($urandom_range(0, 19)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 1023)), 1'b0, 1'b0);
         end
      end

      do_update(7, 1, 2, 1'b0, 1'b1);
      release_reset();
      do_update(0, 11, 22, 1'b0, 1'b0);

      for (int a = 0; a <= TBL_LAST; a++) check($sformatf("table%0d", a), shadow[a], model_tbl[a]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
